// File: rtl/rand_instr_gen.sv
// Random RV32I instruction generator driven by a 32-bit Galois LFSR.
// Warmup NOPs, then class-filtered ALU/load/store words on a valid/ready port.
module rand_instr_gen #(
    parameter logic [31:0] SEED      = 32'h0000_0339,
    parameter int          REG_BITS  = 5,
    parameter logic [3:0]  CLASS_EN  = 4'b0111,
    parameter int          WARMUP    = 4,
    parameter int          NUM_INSTR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_class,
    output logic [15:0] issued_cnt,
    output logic        done
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [4:0]  REG_MASK = 5'((32'd1 << REG_BITS) - 32'd1);
    localparam logic [15:0] WARM_N   = 16'(WARMUP);
    localparam logic [15:0] NUM_N    = 16'(NUM_INSTR);

    typedef enum logic [1:0] {WARM, RUN, DONE} state_t;

    localparam state_t START = (WARMUP == 0) ? RUN : WARM;

    state_t      state, state_n;
    logic [31:0] lfsr, lfsr_n;
    logic [15:0] warm_cnt, warm_n;
    logic [15:0] cnt, cnt_n;
    logic        valid, valid_n;

    logic [1:0]  cls, sel, idx;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm, imm_i;
    logic [6:0]  f7;
    logic        found;
    logic [31:0] rand_instr;
    logic [1:0]  rand_cls;
    logic        accept;

    assign cls = lfsr[1:0];
    assign f3  = lfsr[4:2];
    assign rd  = lfsr[9:5] & REG_MASK;
    assign rs1 = lfsr[14:10] & REG_MASK;
    assign rs2 = lfsr[19:15] & REG_MASK;
    assign imm = lfsr[31:20];

    // First enabled class at or above cls, wrapping past 3 back to 0
    always_comb begin
        sel   = cls;
        found = 1'b0;
        idx   = cls;
        for (int k = 0; k < 4; k++) begin
            idx = cls + 2'(k);
            if (!found && CLASS_EN[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rand_instr = NOP;
        rand_cls   = 2'd0;
        imm_i      = imm;
        f7         = 7'd0;
        if (f3 == 3'd1) imm_i = imm & 12'h01F;
        if (f3 == 3'd5) imm_i = imm & 12'h41F;
        if (f3 == 3'd0 || f3 == 3'd5) f7 = {1'b0, imm[10], 5'd0};
        if (found) begin
            rand_cls = sel;
            case (sel)
                2'd0: rand_instr = {imm_i, rs1, f3, rd, 7'b0010011};
                2'd1: rand_instr = {imm, rs1, f3 & 3'b100, rd, 7'b0000011};
                2'd2: rand_instr = {imm[11:5], rs2, rs1, 3'b000,
                                    imm[4:0], 7'b0100011};
                default: rand_instr = {f7, rs2, rs1, f3, rd, 7'b0110011};
            endcase
        end
    end

    assign accept = valid && out_ready;

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        warm_n  = warm_cnt;
        cnt_n   = cnt;
        valid_n = valid;
        case (state)
            WARM: if (accept) begin
                warm_n = warm_cnt + 16'd1;
                if (warm_n == WARM_N) state_n = RUN;
            end
            RUN: if (accept) begin
                lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
                if (cnt != 16'hFFFF) cnt_n = cnt + 16'd1;
                if (NUM_N != 16'd0 && cnt + 16'd1 == NUM_N) state_n = DONE;
            end
            DONE: state_n = DONE;
            default: state_n = START;
        endcase
        // en only matters once nothing is waiting to be taken
        if (!(valid && !out_ready))
            valid_n = en && (state_n != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= START;
            lfsr     <= SEED_EFF;
            warm_cnt <= 16'd0;
            cnt      <= 16'd0;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            warm_cnt <= warm_n;
            cnt      <= cnt_n;
            valid    <= valid_n;
        end
    end

    assign out_valid  = valid;
    assign out_instr  = (valid && state == RUN) ? rand_instr : NOP;
    assign out_class  = (valid && state == RUN) ? rand_cls : 2'd0;
    assign issued_cnt = cnt;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_rand_instr_gen.sv
// Directed bench for rand_instr_gen: several parameterisations on one clock,
// expected words hand-encoded from the LFSR sequence.
module tb_rand_instr_gen;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        r0;
    logic        r1 = 1'b1;

    logic        v   [6];
    logic [31:0] ins [6];
    logic [1:0]  cl  [6];
    logic [15:0] cnt [6];
    logic        dn  [6];

    int n_chk  = 0;
    int n_pass = 0;

    // SEED=1 sequence: 1, 80200003, C0300002, 60180001, B02C0003,
    // D8360002, 6C1B0001, B62D8003, DB36C002
    logic [31:0] e0 [9] = '{32'h00000003, 32'h00000033, 32'hC00001A3,
                           32'h60100003, 32'h01800033, 32'hD8C001A3,
                           32'h6C100003, 32'h01B00033, 32'hDAD809A3};
    logic [1:0]  c0 [9] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2,
                           2'd1, 2'd3, 2'd2};

    always #5 clk = ~clk;

    rand_instr_gen #(.SEED(32'h1), .CLASS_EN(4'hF), .WARMUP(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .out_valid(v[0]),
        .out_ready(r0), .out_instr(ins[0]), .out_class(cl[0]),
        .issued_cnt(cnt[0]), .done(dn[0]));

    rand_instr_gen #(.SEED(32'h1), .CLASS_EN(4'b0001), .WARMUP(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .out_valid(v[1]),
        .out_ready(r1), .out_instr(ins[1]), .out_class(cl[1]),
        .issued_cnt(cnt[1]), .done(dn[1]));

    rand_instr_gen #(.SEED(32'hFFF00004), .CLASS_EN(4'hF), .WARMUP(0)) u2 (
        .clk(clk), .reset(reset), .en(en), .out_valid(v[2]),
        .out_ready(r1), .out_instr(ins[2]), .out_class(cl[2]),
        .issued_cnt(cnt[2]), .done(dn[2]));

    rand_instr_gen #(.SEED(32'h2), .CLASS_EN(4'hF), .WARMUP(0)) u3 (
        .clk(clk), .reset(reset), .en(en), .out_valid(v[3]),
        .out_ready(r1), .out_instr(ins[3]), .out_class(cl[3]),
        .issued_cnt(cnt[3]), .done(dn[3]));

    rand_instr_gen #(.WARMUP(2), .NUM_INSTR(3)) u4 (
        .clk(clk), .reset(reset), .en(en), .out_valid(v[4]),
        .out_ready(r1), .out_instr(ins[4]), .out_class(cl[4]),
        .issued_cnt(cnt[4]), .done(dn[4]));

    rand_instr_gen #(.SEED(32'h0), .CLASS_EN(4'hF), .WARMUP(0)) u5 (
        .clk(clk), .reset(reset), .en(en), .out_valid(v[5]),
        .out_ready(r1), .out_instr(ins[5]), .out_class(cl[5]),
        .issued_cnt(cnt[5]), .done(dn[5]));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_u0(input string tag, input int i);
        check({tag, "_v"}, 32'(v[0]), 32'd1);
        check({tag, "_ins"}, ins[0], e0[i]);
        check({tag, "_cls"}, 32'(cl[0]), 32'(c0[i]));
        check({tag, "_cnt"}, 32'(cnt[0]), 32'(i));
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        r0    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_v", 32'(v[0]), 32'd0);
        check("rst_cnt", 32'(cnt[0]), 32'd0);
        check("rst_ins", ins[0], NOP);
        check("rst_cls", 32'(cl[0]), 32'd0);
        check("rst_done", 32'(dn[0]), 32'd0);
        check("rst_v4", 32'(v[4]), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_u0("run", i);
            if (i == 0) begin
                check("u1_ins0", ins[1], 32'h00000013);
                check("u1_cls0", 32'(cl[1]), 32'd0);
                check("u2_ins0", ins[2], 32'h01F01013);
                check("u2_cls0", 32'(cl[2]), 32'd0);
                check("u3_ins0", ins[3], 32'h00000023);
                check("u3_cls0", 32'(cl[3]), 32'd2);
                check("u5_ins0", ins[5], 32'h00000003);
                check("u5_cls0", 32'(cl[5]), 32'd1);
            end
            if (i == 1) check("u1_ins1", ins[1], 32'h80200013);
            if (i < 2) begin
                check("u4_wv", 32'(v[4]), 32'd1);
                check("u4_wins", ins[4], NOP);
                check("u4_wcls", 32'(cl[4]), 32'd0);
                check("u4_wcnt", 32'(cnt[4]), 32'd0);
            end
            if (i == 2) begin
                check("u4_ins", ins[4], 32'h00004C83);
                check("u4_cls", 32'(cl[4]), 32'd1);
            end
            if (i >= 2 && i <= 4) begin
                check("u4_rv", 32'(v[4]), 32'd1);
                check("u4_rcnt", 32'(cnt[4]), 32'(i - 2));
                check("u4_rdone", 32'(dn[4]), 32'd0);
            end
            if (i >= 5) begin
                check("u4_dv", 32'(v[4]), 32'd0);
                check("u4_done", 32'(dn[4]), 32'd1);
                check("u4_dcnt", 32'(cnt[4]), 32'd3);
                check("u4_dins", ins[4], NOP);
            end
            if (i == 5) begin
                r0 = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_u0("stall", 5);
                    check("stall_u4done", 32'(dn[4]), 32'd1);
                end
                r0 = 1'b1;
            end
        end

        reset = 1'b1;
        @(negedge clk);
        check("mrst_v", 32'(v[0]), 32'd0);
        check("mrst_cnt", 32'(cnt[0]), 32'd0);
        check("mrst_ins", ins[0], NOP);
        reset = 1'b0;

        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_u0("replay", j);
        end

        en = 1'b0;
        @(negedge clk);
        check("en0_v", 32'(v[0]), 32'd0);
        check("en0_cnt", 32'(cnt[0]), 32'd5);
        @(negedge clk);
        check("en0_v2", 32'(v[0]), 32'd0);
        check("en0_cnt2", 32'(cnt[0]), 32'd5);
        en = 1'b1;
        @(negedge clk);
        check_u0("en1", 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
